// File: rtl/spi_byte_master.sv
// spi_byte_master
// Single-byte, full-duplex SPI master. One byte is accepted per handshake,
// shifted out MSB-first on MOSI while MISO is shifted in, and the received
// byte is returned with a one-cycle valid strobe.
//
// Parameters:
//   SPI_MODE          SPI mode 0-3 (CPOL = SPI_MODE[1], CPHA = SPI_MODE[0])
//   CLKS_PER_HALF_BIT i_Clk cycles per SCLK half-period (must be >= 2)
//
// Ports:
//   i_Clk       system clock, rising edge
//   i_Reset     synchronous active-high reset
//   i_TX_Byte   byte to send, sampled on the accept cycle only
//   i_TX_DV     transmit request, accepted when o_TX_Ready=1
//   o_TX_Ready  idle and able to accept a byte
//   o_RX_DV     one-cycle pulse, o_RX_Byte holds a new byte
//   o_RX_Byte   last received byte
//   o_SPI_Clk   SCLK, idles at CPOL
//   o_SPI_MOSI  serial data out, MSB first
//   i_SPI_MISO  serial data in, MSB first
//   o_SPI_CS_n  active-low chip select (only when SPI_MASTER_CS_EN is defined)
//
// Optional feature macro: SPI_MASTER_CS_EN adds the o_SPI_CS_n output.
module spi_byte_master #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 4
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_SPI_Clk,
  output logic       o_SPI_MOSI,
  input  logic       i_SPI_MISO
`ifdef SPI_MASTER_CS_EN
  ,
  output logic       o_SPI_CS_n
`endif
);

  localparam logic [1:0] MODE = 2'(SPI_MODE);
  localparam logic       CPOL = MODE[1];
  localparam logic       CPHA = MODE[0];

  // Half-bit counter only needs to reach CLKS_PER_HALF_BIT-1.
  localparam int            CW        = $clog2(CLKS_PER_HALF_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_HALF_BIT - 1);

  if (CLKS_PER_HALF_BIT < 2) begin : g_bad_half_bit
    $error("spi_byte_master: CLKS_PER_HALF_BIT must be at least 2");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] half_cnt;
  logic [4:0]    edge_cnt;   // SCLK toggles issued so far, 0..16
  logic [7:0]    tx_shift;   // bits still to be driven, next one in [7]
  logic [7:0]    rx_shift;
  logic          accept;
  logic          toggle;
  logic          done;
  logic          leading;
  logic          sample_edge;
  logic          drive_edge;

  // Odd toggles (edge_cnt even before the increment) are leading edges.
  assign leading     = ~edge_cnt[0];
  assign sample_edge = (leading == ~CPHA);
  // CPHA=1 drives on leading edges; CPHA=0 drives on trailing edges except
  // the last, since bit7 was already placed on MOSI at accept.
  assign drive_edge  = CPHA ? leading : (~leading && (edge_cnt != 5'd15));

  // State register.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    toggle     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (i_TX_DV) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (edge_cnt == 5'd16) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (half_cnt == HALF_LAST) begin
          toggle = 1'b1;
        end else begin
          toggle = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: counters, shift registers and registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      half_cnt   <= '0;
      edge_cnt   <= 5'd0;
      tx_shift   <= 8'h00;
      rx_shift   <= 8'h00;
      o_TX_Ready <= 1'b1;
      o_RX_DV    <= 1'b0;
      o_RX_Byte  <= 8'h00;
      o_SPI_Clk  <= CPOL;
      o_SPI_MOSI <= 1'b0;
    end else begin
      o_RX_DV <= 1'b0;
      if (accept) begin
        half_cnt   <= '0;
        edge_cnt   <= 5'd0;
        o_TX_Ready <= 1'b0;
        if (CPHA) begin
          tx_shift <= i_TX_Byte;
        end else begin
          o_SPI_MOSI <= i_TX_Byte[7];
          tx_shift   <= {i_TX_Byte[6:0], 1'b0};
        end
      end else if (toggle) begin
        half_cnt  <= '0;
        edge_cnt  <= edge_cnt + 5'd1;
        o_SPI_Clk <= ~o_SPI_Clk;
        if (sample_edge) begin
          rx_shift <= {rx_shift[6:0], i_SPI_MISO};
        end
        if (drive_edge) begin
          o_SPI_MOSI <= tx_shift[7];
          tx_shift   <= {tx_shift[6:0], 1'b0};
        end
      end else if (done) begin
        o_RX_Byte  <= rx_shift;
        o_RX_DV    <= 1'b1;
        o_TX_Ready <= 1'b1;
      end else if (state == SHIFT) begin
        half_cnt <= half_cnt + CW'(1);
      end
    end
  end

`ifdef SPI_MASTER_CS_EN
  // Chip select: low from the cycle after accept through the RX_DV cycle,
  // kept low when the next byte is accepted in the RX_DV cycle.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_SPI_CS_n <= 1'b1;
    end else if (state == IDLE) begin
      o_SPI_CS_n <= ~i_TX_DV;
    end else begin
      o_SPI_CS_n <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_byte_master.sv
// Testbench for spi_byte_master: one instance per SPI mode, all driven by
// the same request stream. A slave model per instance serves MISO and
// captures MOSI; expected transfers are queued at issue time and popped by
// a per-instance monitor when o_RX_DV fires.
module tb_spi_byte_master;

  localparam int HALF = 4;
  localparam int XFER = 16 * HALF + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] tx_byte;
  logic       tx_dv;
  logic [3:0] ready;
  logic [3:0] rx_dv;
  logic [3:0] sclk;
  logic [3:0] mosi;
  logic [3:0] miso;
  logic [7:0] rx_byte [4];
`ifdef SPI_MASTER_CS_EN
  logic [3:0] cs_n;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] sl;
    int         t0;
  } exp_t;

  exp_t exp_q [4][$];

  // Reference model of the handshake: a request in cycle c is taken iff
  // c >= busy_until; a taken request occupies XFER cycles.
  int         busy_until = 0;
  int         last_t0    = -1000;
  int         prev_t0    = -1000;
  logic [7:0] cur_slave  = 8'h00;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  for (genvar m = 0; m < 4; m++) begin : g_mode
    localparam int CPOL = m / 2;
    localparam int CPHA = m % 2;

    spi_byte_master #(.SPI_MODE(m), .CLKS_PER_HALF_BIT(HALF)) dut (
      .i_Clk      (clk),
      .i_Reset    (rst),
      .i_TX_Byte  (tx_byte),
      .i_TX_DV    (tx_dv),
      .o_TX_Ready (ready[m]),
      .o_RX_DV    (rx_dv[m]),
      .o_RX_Byte  (rx_byte[m]),
      .o_SPI_Clk  (sclk[m]),
      .o_SPI_MOSI (mosi[m]),
      .i_SPI_MISO (miso[m])
`ifdef SPI_MASTER_CS_EN
      ,
      .o_SPI_CS_n (cs_n[m])
`endif
    );

    int         t = 0;
    int         k;
    logic       prev = 1'b0;
    logic [7:0] cap = 8'h00;
    logic       s_miso = 1'b0;
    bit         idle_exp;
    bit         cs_low_exp;
    exp_t       e;

    assign miso[m] = s_miso;

    // Slave model plus monitor, sampled mid-cycle.
    always @(negedge clk) begin
      if (rst) begin
        t    = 0;
        cap  = 8'h00;
        prev = (CPOL != 0);
      end else begin
        if (sclk[m] != prev) begin
          t++;
          if (exp_q[m].size() == 0) begin
            check("sclk_toggle_outside_xfer", 1, 0);
          end else begin
            check("sclk_toggle_time", cyc, exp_q[m][0].t0 + 1 + HALF * t);
          end
          // The slave samples MOSI on the same edges the master samples MISO.
          if (((t % 2) == 1) == (CPHA == 0)) cap = {cap[6:0], mosi[m]};
        end
        prev = sclk[m];

        if (rx_dv[m]) begin
          if (exp_q[m].size() == 0) begin
            check("rx_dv_unexpected", 1, 0);
          end else begin
            e = exp_q[m].pop_front();
            check("rx_byte", rx_byte[m], e.sl);
            check("slave_saw_mosi", cap, e.tx);
            check("rx_dv_cycle", cyc, e.t0 + XFER);
            check("toggle_count", t, 16);
            check("mosi_hold_last_bit", mosi[m], e.tx[0]);
            check("sclk_at_done", sclk[m], CPOL);
          end
          t   = 0;
          cap = 8'h00;
        end

        // Slave presents the next MSB-first bit after each sample edge.
        k      = (CPHA != 0) ? (t / 2) : ((t + 1) / 2);
        s_miso = (k < 8) ? cur_slave[7 - k] : 1'b0;

        idle_exp = (cyc >= busy_until) || (cyc == last_t0);
        check("tx_ready", ready[m], idle_exp);
        if (idle_exp) check("sclk_idle", sclk[m], CPOL);
`ifdef SPI_MASTER_CS_EN
        cs_low_exp = ((cyc > last_t0) && (cyc <= last_t0 + XFER)) ||
                     ((cyc > prev_t0) && (cyc <= prev_t0 + XFER));
        check("cs_n", cs_n[m], !cs_low_exp);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [7:0] b, input logic [7:0] sl);
    tx_dv   = 1'b1;
    tx_byte = b;
    if (cyc >= busy_until) begin
      prev_t0    = last_t0;
      last_t0    = cyc;
      busy_until = cyc + XFER;
      cur_slave  = sl;
      for (int m = 0; m < 4; m++) exp_q[m].push_back('{tx: b, sl: sl, t0: cyc});
    end
    tick();
    tx_dv   = 1'b0;
    tx_byte = 8'($urandom);
  endtask

  task automatic wait_idle();
    while (cyc < busy_until) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst        = 1'b0;
    busy_until = 0;
    last_t0    = -1000;
    prev_t0    = -1000;
    for (int m = 0; m < 4; m++) begin
      exp_q[m].delete();
      check("reset_ready", ready[m], 1);
      check("reset_sclk", sclk[m], m / 2);
      check("reset_mosi", mosi[m], 0);
      check("reset_rx_byte", rx_byte[m], 0);
      check("reset_rx_dv", rx_dv[m], 0);
`ifdef SPI_MASTER_CS_EN
      check("reset_cs_n", cs_n[m], 1);
`endif
    end
  endtask

  initial begin
    int g;
    rst     = 1'b1;
    tx_dv   = 1'b0;
    tx_byte = 8'h00;
    tick();
    do_reset(3);

    // Echo slave: returns the byte sent.
    request(8'hA5, 8'hA5);
    wait_idle(); tick();

    // Constant-ones byte with a fixed slave pattern.
    request(8'hFF, 8'h3C);
    wait_idle(); tick();

    // Request during the busy window must be ignored.
    request(8'h80, 8'h6E);
    repeat (10) tick();
    request(8'h12, 8'h99);
    wait_idle(); repeat (3) tick();

    // Back-to-back: second request in the RX_DV cycle.
    request(8'hAA, 8'h5C);
    wait_idle();
    request(8'h55, 8'hC5);
    wait_idle(); tick();

    // Reset during the cycle the 7th SCLK toggle is visible.
    request(8'hC3, 8'h81);
    repeat (28) tick();
    do_reset(1);
    request(8'h01, 8'hE7);
    wait_idle(); tick();

    request(8'h5A, 8'h24);
    wait_idle(); tick();

    for (int i = 0; i < 25; i++) begin
      g = $urandom_range(0, 3);
      wait_idle();
      repeat (g) tick();
      request(8'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 60)) tick();
        request(8'($urandom), 8'($urandom));
      end
    end

    wait_idle();
    repeat (3) tick();
    for (int m = 0; m < 4; m++) check("queue_drained", exp_q[m].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_byte_master.md
Name: spi_byte_master

Overview:
Single-byte, full-duplex SPI master used by the SSD1306 display/keyboard controller to stream command and frame bytes to the panel and to read keyboard scan codes over MISO. It accepts one byte per handshake, shifts it out MSB-first on MOSI while shifting in MISO, then returns the received byte with a one-cycle valid strobe. Chip-select and D/C are owned by the parent controller.

Parameters:
SPI_MODE, 0, SPI mode 0-3; CPOL = SPI_MODE[1], CPHA = SPI_MODE[0].
CLKS_PER_HALF_BIT, 4, i_Clk cycles per SCLK half-period; values below 2 are an elaboration error.

Ports:
i_Clk  input  1  system clock; all logic on rising edge
i_Reset  input  1  synchronous, active-high reset
i_TX_Byte  input  8  byte to transmit; sampled on the accept cycle only
i_TX_DV  input  1  transmit request; accepted only when o_TX_Ready=1
o_TX_Ready  output  1  high when idle and able to accept a byte
o_RX_DV  output  1  one-cycle pulse: o_RX_Byte holds a new byte
o_RX_Byte  output  8  last received byte; held until the next completion
o_SPI_Clk  output  1  SCLK; idles at CPOL
o_SPI_MOSI  output  1  serial data out, MSB first
i_SPI_MISO  input  1  serial data in, MSB first

Behaviour:
- Reset (i_Reset=1 at a clock edge), effective that edge:
  - o_SPI_Clk=CPOL, o_SPI_MOSI=0, o_TX_Ready=1, o_RX_DV=0, o_RX_Byte=0.
  - Bit and edge counters cleared.
  - Reset mid-transfer aborts the transfer with no o_RX_DV.
- States: IDLE, SHIFT.
- IDLE:
  - o_TX_Ready=1.
  - Accept cycle T0 is an edge with i_TX_DV=1: latch i_TX_Byte and go to SHIFT.
  - At T0+1: o_TX_Ready=0. If CPHA=0, o_SPI_MOSI also = bit7 at T0+1.
- SHIFT:
  - Generate exactly 16 SCLK toggles spaced CLKS_PER_HALF_BIT cycles apart. The first toggle is at T0+1+CLKS_PER_HALF_BIT.
  - Odd toggles are leading edges; even toggles are trailing edges.
  - CPHA=0: sample i_SPI_MISO on each leading edge. Drive the next MOSI bit on each trailing edge except the 16th.
  - CPHA=1: drive MOSI bit7..bit0 on the leading edges. Sample MISO on the trailing edges.
  - Sampled bits fill an internal shift register MSB first.
- Completion:
  - One cycle after the 16th toggle: o_RX_Byte is updated, o_RX_DV=1 for exactly one cycle, o_TX_Ready=1, return to IDLE.
  - o_SPI_Clk is back at CPOL.
  - o_SPI_MOSI holds its last value until the next transfer.
- Busy requests: i_TX_DV while o_TX_Ready=0 is ignored (no queueing). i_TX_Byte changes after T0 do not affect the current byte.
- Back-to-back: i_TX_DV=1 in the o_RX_DV cycle is accepted, because o_TX_Ready=1 in that cycle.
- Transfer length: a fixed number of cycles from accept to o_RX_DV, 16*CLKS_PER_HALF_BIT+2 for every byte.
- Idle outputs: o_RX_DV=0 at all other times; o_SPI_Clk never toggles outside SHIFT.

Optional Feature:
SPI_MASTER_CS_EN.
- Defined: adds output o_SPI_CS_n (1 bit). Reset value 1. Driven 0 from T0+1 through the o_RX_DV cycle. Returns to 1 the cycle after o_RX_DV unless a new byte is accepted in that cycle, in which case it stays 0.
- Undefined: the port does not exist. The parent drives chip-select, as SSD1306 does with o_CS/o_CS2.

Test Plan:
1. Mode 0, CLKS_PER_HALF_BIT=4, send 0xA5 with MISO loopback from MOSI -> 8 rising SCLK edges with MOSI=1,0,1,0,0,1,0,1 at each rise; o_RX_DV single pulse at T0+66; o_RX_Byte=0xA5; o_TX_Ready low T0+1..T0+65.
2. Mode 3, MISO driven 0x3C by slave model, send 0xFF -> SCLK idles high; o_RX_Byte=0x3C; MOSI constant 1; exactly 16 SCLK toggles.
3. i_TX_DV pulsed with 0x12 during the busy window while 0x80 transfers -> only 0x80 appears on MOSI; one o_RX_DV; no second transfer.
4. Back-to-back: i_TX_DV asserted in the o_RX_DV cycle with 0x55 after 0xAA -> second transfer starts at once; SCLK returns to CPOL between bytes; two o_RX_DV pulses 66 cycles apart.
5. Assert i_Reset at the 7th SCLK toggle of 0xC3 -> next cycle: SCLK=CPOL, MOSI=0, o_TX_Ready=1, o_RX_Byte=0; no o_RX_DV; next transfer of 0x01 completes normally.
6. SPI_MASTER_CS_EN defined, send 0x5A -> o_SPI_CS_n=1 at reset, 0 from T0+1 through the o_RX_DV cycle, then 1.
